digital_clock_p: RTL and testbench

DIGITAL_CLOCK_P -- requirements
Module: digital_clock_p

---
 rtl/digital_clock_pkg.sv | 45 ++++
 rtl/tick_gen.sv | 28 ++
 rtl/digital_clock_p.sv | 117 +++++++++++
 tb/tb_digital_clock_p.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_clock_pkg.sv
// Shared time-of-day limits, field widths and helpers for the digital clock.
package digital_clock_pkg;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
   localparam logic [HOUR_W-1:0] HOUR_12  = 5'd12;

   typedef struct packed {
      logic [HOUR_W-1:0] hour;
      logic [MIN_W-1:0]  minute;
      logic [SEC_W-1:0]  sec;
   } tod_t;

   function automatic logic tod_valid(input tod_t t);
      return (t.hour <= HOUR_MAX) && (t.minute <= MIN_MAX) && (t.sec <= SEC_MAX);
   endfunction

   function automatic logic tod_is_last(input tod_t t);
      return (t.hour == HOUR_MAX) && (t.minute == MIN_MAX) && (t.sec == SEC_MAX);
   endfunction

   // One-second advance with seconds -> minutes -> hours carry chain.
   function automatic tod_t tod_inc(input tod_t t);
      tod_t n;
      n = t;
      if (t.sec == SEC_MAX) begin
         n.sec = '0;
         if (t.minute == MIN_MAX) begin
            n.minute = '0;
            n.hour   = (t.hour == HOUR_MAX) ? '0 : t.hour + HOUR_W'(1);
         end else begin
            n.minute = t.minute + MIN_W'(1);
         end
      end else begin
         n.sec = t.sec + SEC_W'(1);
      end
      return n;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: free-running 0..CLK_FREQ_HZ-1 counter, tick while at terminal count.
module tick_gen #(
   parameter int CLK_FREQ_HZ = 125_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int              CW   = $clog2(CLK_FREQ_HZ);
   localparam logic [CW-1:0]   LAST = CW'(CLK_FREQ_HZ - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr || (r_cnt == LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/digital_clock_p.sv
// 24 h time-of-day clock with validated load, 12/24 h display and optional alarm.
module digital_clock_p
   import digital_clock_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 125_000_000,
   parameter bit ALARM_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_valid,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic [MIN_W-1:0]  set_min,
   input  logic [SEC_W-1:0]  set_sec,
   input  logic              mode_12h,
   input  logic              alarm_on,
   input  logic [HOUR_W-1:0] alarm_hour,
   input  logic [MIN_W-1:0]  alarm_min,
   output logic [SEC_W-1:0]  sec,
   output logic [MIN_W-1:0]  minute,
   output logic [HOUR_W-1:0] hour,
   output logic [HOUR_W-1:0] disp_hour,
   output logic              pm,
   output logic              tick,
   output logic              day_roll,
   output logic              set_err,
   output logic              alarm_hit
);

   tod_t              r_tod;
   tod_t              w_tod_set;
   tod_t              w_tod_inc;
   logic              w_tick;
   logic              w_set_ok;
   logic              w_load;
   logic              w_adv;
   logic              r_day_roll;
   logic              r_set_err;
   logic [HOUR_W-1:0] w_hour_mod;

   assign w_tod_set = {set_hour, set_min, set_sec};
   assign w_tod_inc = tod_inc(r_tod);
   assign w_set_ok  = tod_valid(w_tod_set);
   assign w_load    = set_valid && w_set_ok;
   // Any set request, accepted or rejected, swallows a coincident tick.
   assign w_adv     = w_tick && !set_valid;

   tick_gen #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_load),
      .tick (w_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tod      <= '0;
         r_day_roll <= 1'b0;
         r_set_err  <= 1'b0;
      end else begin
         r_day_roll <= w_adv && tod_is_last(r_tod);
         r_set_err  <= set_valid && !w_set_ok;
         if (w_load) begin
            r_tod <= w_tod_set;
         end else if (w_adv) begin
            r_tod <= w_tod_inc;
         end
      end
   end

   generate
      if (ALARM_EN) begin : g_alarm
         logic r_alarm_hit;
         logic w_alarm_match;

         assign w_alarm_match = alarm_on
                             && (alarm_hour <= HOUR_MAX) && (alarm_min <= MIN_MAX)
                             && (w_tod_inc.hour == alarm_hour)
                             && (w_tod_inc.minute == alarm_min)
                             && (w_tod_inc.sec == '0);

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_alarm_hit <= 1'b0;
            end else begin
               r_alarm_hit <= w_adv && w_alarm_match;
            end
         end

         assign alarm_hit = r_alarm_hit;
      end else begin : g_no_alarm
         assign alarm_hit = 1'b0;
      end
   endgenerate

   always_comb begin
      w_hour_mod = r_tod.hour;
      if (r_tod.hour >= HOUR_12) begin
         w_hour_mod = r_tod.hour - HOUR_12;
      end
      disp_hour = r_tod.hour;
      pm        = 1'b0;
      if (mode_12h) begin
         pm        = (r_tod.hour >= HOUR_12);
         disp_hour = (w_hour_mod == '0) ? HOUR_12 : w_hour_mod;
      end
   end

   assign sec      = r_tod.sec;
   assign minute   = r_tod.minute;
   assign hour     = r_tod.hour;
   assign tick     = w_tick;
   assign day_roll = r_day_roll;
   assign set_err  = r_set_err;

endmodule

// File: tb/tb_digital_clock_p.sv
// Self-checking bench for digital_clock_p: seconds-of-day reference model plus directed cases.
module tb_digital_clock_p;

   localparam int F = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       set_valid = 1'b0;
   logic [4:0] set_hour = '0;
   logic [5:0] set_min = '0;
   logic [5:0] set_sec = '0;
   logic       mode_12h = 1'b0;
   logic       alarm_on = 1'b0;
   logic [4:0] alarm_hour = '0;
   logic [5:0] alarm_min = '0;

   logic [5:0] sec;
   logic [5:0] minute;
   logic [4:0] hour;
   logic [4:0] disp_hour;
   logic       pm;
   logic       tick;
   logic       day_roll;
   logic       set_err;
   logic       alarm_hit;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: time as seconds of day, prescaler as plain integer
   int m_s  = 0;
   int m_p  = 0;
   bit m_dr = 1'b0;
   bit m_er = 1'b0;
   bit m_ah = 1'b0;

   digital_clock_p #(
      .CLK_FREQ_HZ(F),
      .ALARM_EN   (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .set_valid  (set_valid),
      .set_hour   (set_hour),
      .set_min    (set_min),
      .set_sec    (set_sec),
      .mode_12h   (mode_12h),
      .alarm_on   (alarm_on),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .sec        (sec),
      .minute     (minute),
      .hour       (hour),
      .disp_hour  (disp_hour),
      .pm         (pm),
      .tick       (tick),
      .day_roll   (day_roll),
      .set_err    (set_err),
      .alarm_hit  (alarm_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_s = 0; m_p = 0; m_dr = 1'b0; m_er = 1'b0; m_ah = 1'b0;
      end else begin
         m_dr = 1'b0; m_er = 1'b0; m_ah = 1'b0;
         if (set_valid) begin
            if (int'(set_hour) < 24 && int'(set_min) < 60 && int'(set_sec) < 60) begin
               m_s = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
               m_p = 0;
            end else begin
               m_er = 1'b1;
               m_p  = (m_p + 1) % F;
            end
         end else begin
            if (m_p == F - 1) begin
               m_s  = (m_s + 1) % 86400;
               m_dr = (m_s == 0);
               m_ah = alarm_on && int'(alarm_hour) < 24 && int'(alarm_min) < 60
                      && m_s == int'(alarm_hour) * 3600 + int'(alarm_min) * 60;
            end
            m_p = (m_p + 1) % F;
         end
      end
   end

   always @(negedge clk) begin
      int h;
      h = m_s / 3600;
      chk("sec", int'(sec), m_s % 60);
      chk("minute", int'(minute), (m_s / 60) % 60);
      chk("hour", int'(hour), h);
      chk("disp_hour", int'(disp_hour), mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h);
      chk("pm", int'(pm), (mode_12h && h >= 12) ? 1 : 0);
      chk("tick", int'(tick), (m_p == F - 1) ? 1 : 0);
      chk("day_roll", int'(day_roll), int'(m_dr));
      chk("set_err", int'(set_err), int'(m_er));
      chk("alarm_hit", int'(alarm_hit), int'(m_ah));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input int h, input int m, input int s);
      set_hour  = 5'(h);
      set_min   = 6'(m);
      set_sec   = 6'(s);
      set_valid = 1'b1;
      step();
      set_valid = 1'b0;
   endtask

   // step through the next tick edge, bounded
   task automatic wait_tick_edge(input string name);
      int n;
      n = 0;
      while (tick !== 1'b1 && n < 3 * F) begin
         step();
         n++;
      end
      chk(name, int'(tick), 1);
      step();
   endtask

   task automatic chk_time(input string name, input int h, input int m, input int s);
      chk({name, "_h"}, int'(hour), h);
      chk({name, "_m"}, int'(minute), m);
      chk({name, "_s"}, int'(sec), s);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hrs[4]  = '{0, 11, 12, 13};
      int dhr[4]  = '{12, 11, 12, 1};
      int pms[4]  = '{0, 0, 1, 1};
      int n;

      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // cycle 0 begins at release
      for (int i = 0; i < 8; i++) begin
         chk("rel_tick", int'(tick), (i == 3 || i == 7) ? 1 : 0);
         step();
      end
      chk("rel_sec", int'(sec), 2);

      load(23, 59, 58);
      chk_time("load_2359", 23, 59, 58);
      wait_tick_edge("roll_wait1");
      chk_time("roll_a", 23, 59, 59);
      chk("roll_a_dr", int'(day_roll), 0);
      wait_tick_edge("roll_wait2");
      chk_time("roll_b", 0, 0, 0);
      chk("roll_b_dr", int'(day_roll), 1);
      step();
      chk("roll_c_dr", int'(day_roll), 0);

      load(24, 0, 0);
      chk("rej1_err", int'(set_err), 1);
      chk_time("rej1", 0, 0, 0);
      load(12, 60, 0);
      chk("rej2_err", int'(set_err), 1);
      chk_time("rej2", 0, 0, 0);
      chk("rej_prescale_tick", int'(tick), 1);
      step();
      chk("rej_after_sec", int'(sec), 1);

      n = 0;
      while (tick !== 1'b1 && n < 3 * F) begin
         step();
         n++;
      end
      chk("pri_wait", int'(tick), 1);
      load(7, 30, 15);
      chk_time("pri", 7, 30, 15);
      chk("pri_tick", int'(tick), 0);
      repeat (3) step();
      chk("pri_before_s", int'(sec), 15);
      step();
      chk_time("pri_next", 7, 30, 16);

      mode_12h = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load(hrs[i], 0, 0);
         chk("m12_disp", int'(disp_hour), dhr[i]);
         chk("m12_pm", int'(pm), pms[i]);
      end
      mode_12h = 1'b0;

      alarm_hour = 5'd6;
      alarm_min  = 6'd5;
      alarm_on   = 1'b1;
      load(6, 4, 59);
      wait_tick_edge("al_wait1");
      chk("al_hit", int'(alarm_hit), 1);
      chk_time("al_time", 6, 5, 0);
      step();
      chk("al_once", int'(alarm_hit), 0);
      alarm_on = 1'b0;
      load(6, 4, 59);
      wait_tick_edge("al_wait2");
      chk("al_off", int'(alarm_hit), 0);
      chk("al_off_min", int'(minute), 5);

      alarm_on   = 1'b1;
      alarm_hour = 5'd0;
      alarm_min  = 6'd0;
      load(23, 59, 59);
      wait_tick_edge("mid_wait");
      chk("mid_hit", int'(alarm_hit), 1);
      chk("mid_dr", int'(day_roll), 1);

      alarm_hour = 5'd5;
      alarm_min  = 6'd60;
      load(5, 59, 59);
      wait_tick_edge("oor_wait");
      chk("oor_hit", int'(alarm_hit), 0);
      chk("oor_hour", int'(hour), 6);

      step();
      step();
      rst = 1'b0;
      #1;
      chk_time("rst_now", 0, 0, 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_dr", int'(day_roll), 0);
      chk("rst_err", int'(set_err), 0);
      chk("rst_hit", int'(alarm_hit), 0);
      chk("rst_disp", int'(disp_hour), 0);
      step();
      rst = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         int r;
         int hh;
         int mm;
         int ss;
         r   = $urandom_range(0, 199);
         rst = 1'b1;
         set_valid = 1'b0;
         if (r < 20) begin
            if ($urandom_range(0, 3) == 0) begin
               set_hour = 5'($urandom_range(0, 31));
               set_min  = 6'($urandom_range(0, 63));
               set_sec  = 6'($urandom_range(0, 63));
            end else begin
               hh = ($urandom_range(0, 2) == 0) ? 23 : $urandom_range(0, 23);
               mm = ($urandom_range(0, 1) == 0) ? 59 : $urandom_range(0, 59);
               ss = $urandom_range(55, 59);
               set_hour = 5'(hh);
               set_min  = 6'(mm);
               set_sec  = 6'(ss);
               if ($urandom_range(0, 1) == 0) begin
                  alarm_hour = 5'(((hh * 60 + mm + 1) / 60) % 24);
                  alarm_min  = 6'((hh * 60 + mm + 1) % 60);
               end
            end
            set_valid = 1'b1;
         end else if (r < 24) begin
            mode_12h = ~mode_12h;
         end else if (r < 28) begin
            alarm_on = ~alarm_on;
         end else if (r == 28) begin
            alarm_hour = 5'($urandom_range(0, 25));
            alarm_min  = 6'($urandom_range(0, 61));
         end else if (r == 199) begin
            rst = 1'b0;
         end
         step();
      end
      rst       = 1'b1;
      set_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
